// File: rtl/ss_pkg.sv
// Shared types and defaults for the SG memory-port Wishbone arbiter.
package ss_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int unsigned QUOTA_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W       = 8;

  // One-hot grant vector for a 1-bit owner index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ss_wbarb_mux.sv
// Owner-selected request mux toward the slave and response demux back to the masters.
module ss_wbarb_mux (
  input  logic        owner,
  input  logic        cyc_en,
  input  logic        stb_en,
  input  logic        rsp_en,
  input  logic        force_err,
  input  logic        force_rty,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic        m0_cab,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_dat64_i,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic        m1_cab,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_dat64_i,
  input  logic [31:0] s_dat_o,
  input  logic [31:0] s_dat64_o,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  output logic        own_cyc,
  output logic        own_stb,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic        s_cab,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_i,
  output logic [31:0] s_dat64_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat64_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat64_o,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty
);

  logic o_ack, o_err, o_rty;

  assign own_cyc   = owner ? m1_cyc     : m0_cyc;
  assign own_stb   = owner ? m1_stb     : m0_stb;
  assign s_cyc     = cyc_en & own_cyc;
  assign s_stb     = stb_en & own_stb;
  assign s_we      = owner ? m1_we      : m0_we;
  assign s_cab     = owner ? m1_cab     : m0_cab;
  assign s_sel     = owner ? m1_sel     : m0_sel;
  assign s_adr     = owner ? m1_adr     : m0_adr;
  assign s_dat_i   = owner ? m1_dat_i   : m0_dat_i;
  assign s_dat64_i = owner ? m1_dat64_i : m0_dat64_i;

  // Read data is broadcast; only the handshake is owner-qualified.
  assign m0_dat_o   = s_dat_o;
  assign m0_dat64_o = s_dat64_o;
  assign m1_dat_o   = s_dat_o;
  assign m1_dat64_o = s_dat64_o;

  assign o_ack = rsp_en & s_ack;
  assign o_err = (rsp_en & s_err) | force_err;
  assign o_rty = (rsp_en & s_rty) | force_rty;

  assign m0_ack = ~owner & o_ack;
  assign m0_err = ~owner & o_err;
  assign m0_rty = ~owner & o_rty;
  assign m1_ack = owner & o_ack;
  assign m1_err = owner & o_err;
  assign m1_rty = owner & o_rty;

endmodule

// File: rtl/ss_wbarb.sv
// Two-master round-robin Wishbone arbiter for the shared 64-bit SG memory port,
// with a per-grant beat quota (rty) and a stall watchdog (err + block).
module ss_wbarb
  import ss_pkg::*;
#(
  parameter int unsigned QUOTA   = QUOTA_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic        m0_cab,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_dat64_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat64_o,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic        m1_cab,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_dat64_i,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat64_o,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic        s_cab,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_i,
  output logic [31:0] s_dat64_i,
  input  logic [31:0] s_dat_o,
  input  logic [31:0] s_dat64_o,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  output logic [1:0]  arb_gnt,
  output logic        arb_tmo
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [1:0]       blk_q, blk_d;
  logic [1:0]       gnt_q, gnt_d;

  logic own_cyc, own_stb;
  logic cyc_en, stb_en, rsp_en, force_err, force_rty;
  logic elig0, elig1, other_elig, any_rsp, wd_lim, wd_fire, quota_hit;

  assign elig0      = m0_cyc & ~blk_q[0];
  assign elig1      = m1_cyc & ~blk_q[1];
  assign other_elig = owner_q ? elig0 : elig1;
  assign any_rsp    = s_ack | s_err | s_rty;
  assign wd_lim     = (wdog_q == CNT_W'(TIMEOUT - 1));
  assign quota_hit  = (beat_q == CNT_W'(QUOTA)) & other_elig;

  // A draining owner is timed unconditionally; an active owner only while strobing unanswered.
  assign wd_fire = ((state_q == S_OWN) & wd_lim & own_stb & ~any_rsp) |
                   ((state_q == S_DRAIN) & wd_lim);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= 1'b0;
      beat_q  <= '0;
      wdog_q  <= '0;
      blk_q   <= 2'b00;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      beat_q  <= beat_d;
      wdog_q  <= wdog_d;
      blk_q   <= blk_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state, counters and block bits.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    beat_d  = beat_q;
    wdog_d  = wdog_q;
    blk_d   = blk_q & {m1_cyc, m0_cyc};
    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          owner_d = (elig0 & elig1) ? ~last_q : elig1;
          beat_d  = '0;
          wdog_d  = '0;
          state_d = S_OWN;
        end
      end
      S_OWN, S_DRAIN: begin
        if (wd_fire) begin
          blk_d[owner_q] = 1'b1;
          tmo_d          = 1'b1;
          last_d         = owner_q;
          state_d        = S_IDLE;
        end else if (!own_cyc) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (state_q == S_DRAIN) begin
          wdog_d = wdog_q + CNT_W'(1);
        end else if (quota_hit) begin
          wdog_d  = '0;
          state_d = S_DRAIN;
        end else begin
          if (s_ack && (beat_q != '1)) beat_d = beat_q + CNT_W'(1);
          if (any_rsp)      wdog_d = '0;
          else if (own_stb) wdog_d = wdog_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    gnt_d = (state_d == S_IDLE) ? 2'b00 : onehot2(owner_d);
  end

  // Bus enables and forced responses for the current owner.
  always_comb begin
    cyc_en    = 1'b0;
    stb_en    = 1'b0;
    rsp_en    = 1'b0;
    force_err = 1'b0;
    force_rty = 1'b0;
    case (state_q)
      S_OWN: begin
        if (wd_fire) begin
          force_err = 1'b1;
        end else if (own_cyc) begin
          cyc_en = 1'b1;
          if (quota_hit) begin
            force_rty = 1'b1;
          end else begin
            stb_en = 1'b1;
            rsp_en = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (wd_fire) force_err = 1'b1;
        else         force_rty = own_cyc;
      end
      default: ;
    endcase
  end

  assign arb_gnt = gnt_q;
  assign arb_tmo = tmo_q;

  ss_wbarb_mux u_mux (
    .owner      (owner_q),
    .cyc_en     (cyc_en),
    .stb_en     (stb_en),
    .rsp_en     (rsp_en),
    .force_err  (force_err),
    .force_rty  (force_rty),
    .m0_cyc     (m0_cyc),
    .m0_stb     (m0_stb),
    .m0_we      (m0_we),
    .m0_cab     (m0_cab),
    .m0_sel     (m0_sel),
    .m0_adr     (m0_adr),
    .m0_dat_i   (m0_dat_i),
    .m0_dat64_i (m0_dat64_i),
    .m1_cyc     (m1_cyc),
    .m1_stb     (m1_stb),
    .m1_we      (m1_we),
    .m1_cab     (m1_cab),
    .m1_sel     (m1_sel),
    .m1_adr     (m1_adr),
    .m1_dat_i   (m1_dat_i),
    .m1_dat64_i (m1_dat64_i),
    .s_dat_o    (s_dat_o),
    .s_dat64_o  (s_dat64_o),
    .s_ack      (s_ack),
    .s_err      (s_err),
    .s_rty      (s_rty),
    .own_cyc    (own_cyc),
    .own_stb    (own_stb),
    .s_cyc      (s_cyc),
    .s_stb      (s_stb),
    .s_we       (s_we),
    .s_cab      (s_cab),
    .s_sel      (s_sel),
    .s_adr      (s_adr),
    .s_dat_i    (s_dat_i),
    .s_dat64_i  (s_dat64_i),
    .m0_dat_o   (m0_dat_o),
    .m0_dat64_o (m0_dat64_o),
    .m1_dat_o   (m1_dat_o),
    .m1_dat64_o (m1_dat64_o),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m0_rty     (m0_rty),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .m1_rty     (m1_rty)
  );

endmodule

// File: tb/tb_ss_wbarb.sv
// Bench for ss_wbarb: per-cycle comparison against a grant-level model plus directed literal checks.
module tb_ss_wbarb;

  localparam int QUOTA   = 16;
  localparam int TIMEOUT = 8;

  logic        clk, rst;
  logic        m0_cyc, m0_stb, m0_we, m0_cab, m1_cyc, m1_stb, m1_we, m1_cab;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat_i, m0_dat64_i, m1_adr, m1_dat_i, m1_dat64_i;
  logic [31:0] m0_dat_o, m0_dat64_o, m1_dat_o, m1_dat64_o;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_cyc, s_stb, s_we, s_cab;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_i, s_dat64_i, s_dat_o, s_dat64_o;
  logic        s_ack, s_err, s_rty;
  logic [1:0]  arb_gnt;
  logic        arb_tmo;

  int n_cmp = 0;
  int n_fail = 0;
  int cnt_ack0 = 0, cnt_rty0 = 0, cnt_err1 = 0, cnt_rsp1 = 0;

  // Model state: who holds the grant (-1 none), whether it is being drained by rty,
  // acks granted so far, unanswered-strobe/drain cycles, blocked masters, sticky timeout.
  int       m_own = -1;
  bit       m_drain = 0;
  int       m_last = 1;
  int       m_acks = 0;
  int       m_stall = 0;
  bit [1:0] m_blk = 0;
  bit       m_tmo = 0;

  ss_wbarb #(.QUOTA(QUOTA), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_cab(m0_cab), .m0_sel(m0_sel),
    .m0_adr(m0_adr), .m0_dat_i(m0_dat_i), .m0_dat64_i(m0_dat64_i),
    .m0_dat_o(m0_dat_o), .m0_dat64_o(m0_dat64_o), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_cab(m1_cab), .m1_sel(m1_sel),
    .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_dat64_i(m1_dat64_i),
    .m1_dat_o(m1_dat_o), .m1_dat64_o(m1_dat64_o), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_cab(s_cab), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat_i(s_dat_i), .s_dat64_i(s_dat64_i),
    .s_dat_o(s_dat_o), .s_dat64_o(s_dat64_o), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .arb_gnt(arb_gnt), .arb_tmo(arb_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_dat_o   = s_dat_o + 32'd1;
      s_dat64_o = ~s_dat_o;
    end
  endtask

  task automatic drv0(input logic v); m0_cyc = v; m0_stb = v; endtask
  task automatic drv1(input logic v); m1_cyc = v; m1_stb = v; endtask

  task automatic clr_cnt;
    cnt_ack0 = 0; cnt_rty0 = 0; cnt_err1 = 0; cnt_rsp1 = 0;
  endtask

  // Waits (bounded) for m0_rty (which=0) or m1_err (which=1), sampled on negedges.
  task automatic wait_rsp(input int which, output int n, output bit found);
    found = 0;
    n = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      if ((which == 0) ? m0_rty : m1_err) found = 1;
    end
  endtask

  // Per-cycle model evaluation and comparison.
  always @(negedge clk) begin : cmp
    logic [1:0]   mc, ms, e_ack, e_err, e_rty, e_gnt, n_blk, elig;
    logic         e_scyc, e_sstb, anyr, hung, n_drain, n_tmo;
    logic [10:0]  e_v, a_v;
    logic [101:0] e_req, a_req;
    int           o, n_own, n_last, n_acks, n_stall;

    if (rst) begin
      m_own = -1; m_drain = 0; m_last = 1; m_acks = 0; m_stall = 0; m_blk = 0; m_tmo = 0;
    end
    mc = {m1_cyc, m0_cyc};
    ms = {m1_stb, m0_stb};
    anyr = s_ack | s_err | s_rty;
    e_ack = 0; e_err = 0; e_rty = 0; e_gnt = 0; e_scyc = 0; e_sstb = 0;
    n_own = m_own; n_drain = m_drain; n_last = m_last; n_acks = m_acks; n_stall = m_stall;
    n_tmo = m_tmo; n_blk = m_blk & mc;
    o = 0;

    if (m_own < 0) begin
      elig = mc & ~m_blk;
      if (elig != 2'b00) begin
        n_own = (elig == 2'b11) ? 1 - m_last : (elig[1] ? 1 : 0);
        n_drain = 0; n_acks = 0; n_stall = 0;
      end
    end else begin
      o = m_own;
      e_gnt = (o == 1) ? 2'b10 : 2'b01;
      hung = m_drain ? (m_stall == TIMEOUT - 1) : (ms[o] && !anyr && m_stall == TIMEOUT - 1);
      if (hung) begin
        e_err[o] = 1'b1; n_blk[o] = 1'b1; n_tmo = 1; n_last = o; n_own = -1;
      end else if (!mc[o]) begin
        n_last = o; n_own = -1;
      end else if (m_drain) begin
        e_rty[o] = 1'b1; n_stall = m_stall + 1;
      end else if (m_acks == QUOTA && mc[1-o] && !m_blk[1-o]) begin
        e_scyc = 1; e_rty[o] = 1'b1; n_drain = 1; n_stall = 0;
      end else begin
        e_scyc = 1; e_sstb = ms[o];
        e_ack[o] = s_ack; e_err[o] = s_err; e_rty[o] = s_rty;
        if (s_ack && m_acks < 255) n_acks = m_acks + 1;
        if (anyr) n_stall = 0;
        else if (ms[o]) n_stall = m_stall + 1;
      end
    end

    e_v = {e_gnt, m_tmo, e_scyc, e_sstb, e_ack[1], e_err[1], e_rty[1], e_ack[0], e_err[0], e_rty[0]};
    a_v = {arb_gnt, arb_tmo, s_cyc, s_stb, m1_ack, m1_err, m1_rty, m0_ack, m0_err, m0_rty};
    n_cmp++;
    if (a_v !== e_v) begin
      n_fail++;
      $display("FAIL ctl @%0t: got %b want %b (gnt,tmo,scyc,sstb,m1 a/e/r,m0 a/e/r)", $time, a_v, e_v);
    end

    if (e_scyc) begin
      a_req = {s_adr, s_dat_i, s_dat64_i, s_sel, s_we, s_cab};
      e_req = (o == 1) ? {m1_adr, m1_dat_i, m1_dat64_i, m1_sel, m1_we, m1_cab}
                       : {m0_adr, m0_dat_i, m0_dat64_i, m0_sel, m0_we, m0_cab};
      n_cmp++;
      if (a_req !== e_req) begin
        n_fail++;
        $display("FAIL req_mux @%0t: got %h want %h", $time, a_req, e_req);
      end
    end

    if (!rst) begin
      n_cmp++;
      if ({m0_dat_o, m0_dat64_o, m1_dat_o, m1_dat64_o} !== {s_dat_o, s_dat64_o, s_dat_o, s_dat64_o}) begin
        n_fail++;
        $display("FAIL rd_data @%0t: got %h %h want %h", $time, m0_dat_o, m1_dat_o, s_dat_o);
      end
      m_own = n_own; m_drain = n_drain; m_last = n_last; m_acks = n_acks;
      m_stall = n_stall; m_blk = n_blk; m_tmo = n_tmo;
    end

    cnt_ack0 += int'(m0_ack);
    cnt_rty0 += int'(m0_rty);
    cnt_err1 += int'(m1_err);
    cnt_rsp1 += int'(m1_ack | m1_err | m1_rty);
  end

  initial begin : stim
    int  n;
    bit  found;

    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_cab = 1; m0_sel = 4'hF;
    m0_adr = 32'h1000_0040; m0_dat_i = 32'h0D0D_0001; m0_dat64_i = 32'h0D0D_0002;
    m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_cab = 0; m1_sel = 4'h3;
    m1_adr = 32'h2000_0080; m1_dat_i = 32'h1D1D_0001; m1_dat64_i = 32'h1D1D_0002;
    s_dat_o = 32'hA500_0000; s_dat64_o = 32'h5A00_0000;
    s_ack = 0; s_err = 0; s_rty = 0;

    tick(2);
    chk("rst_gnt", 32'(arb_gnt), 32'd0);
    chk("rst_scyc", 32'(s_cyc), 32'd0);
    chk("rst_tmo", 32'(arb_tmo), 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: single master, 8 acked beats.
    clr_cnt();
    drv0(1); s_ack = 1;
    #1 chk("t1_scyc_req_cycle", 32'(s_cyc), 32'd0);
    tick(1);
    chk("t1_scyc_next", 32'(s_cyc), 32'd1);
    chk("t1_gnt", 32'(arb_gnt), 32'd1);
    tick(8);
    drv0(0);
    tick(1);
    chk("t1_gnt_rel", 32'(arb_gnt), 32'd0);
    chk("t1_acks", 32'(cnt_ack0), 32'd8);
    chk("t1_m1_quiet", 32'(cnt_rsp1), 32'd0);

    // 2: simultaneous request after reset -> m0 then m1, one idle cycle between.
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    drv0(1); drv1(1); s_ack = 1;
    tick(1);
    chk("t2_gnt_m0", 32'(arb_gnt), 32'd1);
    tick(3);
    drv0(0);
    tick(1);
    chk("t2_gnt_gap", 32'(arb_gnt), 32'd0);
    tick(1);
    chk("t2_gnt_m1", 32'(arb_gnt), 32'd2);
    tick(1);
    s_ack = 0; s_err = 1;
    tick(1);
    s_ack = 1; s_err = 0;
    tick(1);
    drv1(0);
    tick(2);

    // 3: quota with m1 waiting.
    clr_cnt();
    drv0(1); s_ack = 1;
    tick(1);
    drv1(1);
    wait_rsp(0, n, found);
    chk("t3_rty_seen", 32'(found), 32'd1);
    chk("t3_rty_cycle", 32'(n), 32'd17);
    chk("t3_stb_masked", 32'(s_stb), 32'd0);
    @(posedge clk); #1;
    chk("t3_acks", 32'(cnt_ack0), 32'd16);
    chk("t3_rty_held", 32'(m0_rty), 32'd1);
    chk("t3_drain_scyc", 32'(s_cyc), 32'd0);
    tick(1);
    drv0(0);
    tick(2);
    chk("t3_gnt_m1", 32'(arb_gnt), 32'd2);
    tick(2);
    drv1(0);
    tick(2);

    // 4: quota reached with m1 idle -> no rty.
    clr_cnt();
    drv0(1); s_ack = 1;
    tick(41);
    drv0(0);
    tick(2);
    chk("t4_acks", 32'(cnt_ack0), 32'd40);
    chk("t4_no_rty", 32'(cnt_rty0), 32'd0);

    // 5: unresponsive slave for m1 -> watchdog err, block until m1 drops cyc.
    clr_cnt();
    drv1(1); s_ack = 0;
    wait_rsp(1, n, found);
    chk("t5_err_seen", 32'(found), 32'd1);
    chk("t5_err_cycle", 32'(n), 32'd9);
    @(posedge clk); #1;
    chk("t5_tmo", 32'(arb_tmo), 32'd1);
    chk("t5_gnt_rel", 32'(arb_gnt), 32'd0);
    drv0(1); s_ack = 1;
    tick(1);
    chk("t5_gnt_m0", 32'(arb_gnt), 32'd1);
    tick(2);
    drv0(0);
    tick(3);
    chk("t5_m1_blocked", 32'(arb_gnt), 32'd0);
    chk("t5_err_pulse", 32'(cnt_err1), 32'd1);
    m1_cyc = 0; m1_stb = 0;
    tick(1);
    drv1(1);
    tick(1);
    chk("t5_m1_regrant", 32'(arb_gnt), 32'd2);
    tick(1);
    drv1(0);
    tick(2);

    // 6: reset during drain, then tie goes to m0.
    drv0(1); drv1(1); s_ack = 1;
    wait_rsp(0, n, found);
    chk("t6_rty_seen", 32'(found), 32'd1);
    tick(2);
    chk("t6_drain_rty", 32'(m0_rty), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_scyc", 32'(s_cyc), 32'd0);
    chk("t6_rst_rsp", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'd0);
    chk("t6_rst_gnt", 32'(arb_gnt), 32'd0);
    chk("t6_rst_tmo", 32'(arb_tmo), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("t6_tie_m0", 32'(arb_gnt), 32'd1);
    drv0(0); drv1(0); s_ack = 0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : guard
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/ss_wbarb.md
Name: ss_wbarb

Overview:
- Two-master Wishbone arbiter. It shares the single 64-bit SG memory port between the source-side and destination-side scatter-gather readers under ss_adma.
- Grants are round-robin and registered.
- A per-grant beat quota is enforced via rty, so long buffer bursts yield to pending descriptor fetches.
- A stall watchdog force-releases a hung owner with err.

Parameters:
QUOTA, 16, acks per grant before rty is issued if the other master is requesting (1..255)
TIMEOUT, 255, cycles with s_stb high and no ack/err/rty before watchdog fires (2..255)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous reset, active-high
mN_cyc, mN_stb, mN_we, mN_cab  in  1 each  master N (N=0,1) request
mN_sel  in  4  master N byte select
mN_adr  in  32  master N address
mN_dat_i, mN_dat64_i  in  32 each  master N write data low/high
mN_dat_o, mN_dat64_o  out  32 each  read data to master N
mN_ack, mN_err, mN_rty  out  1 each  response to master N
s_cyc, s_stb, s_we, s_cab  out  1 each  to memory slave
s_sel  out  4  to slave
s_adr, s_dat_i, s_dat64_i  out  32 each  to slave
s_dat_o, s_dat64_o  in  32 each  slave read data
s_ack, s_err, s_rty  in  1 each  slave response
arb_gnt  out  2  one-hot current owner, 00 = none
arb_tmo  out  1  sticky watchdog flag, cleared only by reset

Behaviour:
- States: S_IDLE, S_OWN, S_DRAIN (2-bit). Registers: state, owner, last (last served), beat[7:0], wdog[7:0], blk[1:0], arb_tmo.
- Reset: state=S_IDLE, owner=0, last=1 (m0 wins first tie), beat=0, wdog=0, blk=0, arb_tmo=0, arb_gnt=00. s_cyc, s_stb and all mN_ack/err/rty are 0 during and after reset. Data outputs are don't-care.
- Eligible requester N: mN_cyc & ~blk[N].
- blk[N] clears in any cycle where mN_cyc=0.
- S_IDLE:
  - If any master is eligible, pick it. If both are eligible, pick the one != last.
  - Load owner, clear beat and wdog, go to S_OWN.
  - Latency: request to s_cyc is exactly 1 cycle.
- S_OWN:
  - s_cyc = owner cyc. s_stb, we, cab, sel, adr, dat are the owner's signals, combinationally muxed.
  - s_dat_o/s_dat64_o go to both masters. s_ack/s_err/s_rty route only to the owner; the non-owner sees 0.
  - On owner ack: beat++ (saturating at 255), wdog=0.
  - On owner rty or err: wdog=0.
  - While s_stb and no response: wdog++.
  - Owner drops cyc: last=owner, go to S_IDLE. That cycle has s_cyc=0.
  - Quota: when beat==QUOTA and the other master is eligible, force s_stb=0 and assert owner rty=1 (slave ack is masked; none can arrive since stb=0). Go to S_DRAIN.
  - Watchdog: when wdog==TIMEOUT-1 with no response, assert owner err=1 for 1 cycle, s_cyc=0, set blk[owner] and arb_tmo, last=owner, go to S_IDLE.
- S_DRAIN:
  - s_cyc=0, s_stb=0. Owner rty held at 1 until owner cyc=0.
  - Then last=owner, go to S_IDLE.
  - wdog counts every cycle. On reaching TIMEOUT-1, apply the same err/blk release as in S_OWN. This covers descriptor fetches that ignore rty.
- Simultaneous events, in priority order: watchdog > owner cyc drop > quota > normal.
- Slave err passes through unchanged; the arbiter does not block on slave err.
- Reset mid-transfer: outputs drop asynchronously. A master's in-flight cycle gets no response.
- Both masters request while a grant is held: the non-owner waits with no response, and no combinational path exists from its cyc to its outputs.

Decomposition:
- Shared package ss_pkg: state encodings S_IDLE/S_OWN/S_DRAIN and default QUOTA/TIMEOUT constants.
- One natural sub-module: ss_wbarb_mux, the purely combinational owner-selected request mux and response demux. The FSM, counters and blk stay in ss_wbarb.

Test Plan:
1. m0 cyc alone, slave acks every cycle for 8 beats, m0 drops cyc -> s_cyc one cycle after m0_cyc; 8 m0_ack; m1 outputs 0; arb_gnt 01 then 00.
2. m0 and m1 assert cyc in the same cycle from reset -> m0 granted first; after m0 releases, m1 granted (arb_gnt 10) with one idle cycle between.
3. QUOTA=16: m0 bursts while m1 requests -> after the 16th ack, m0_rty=1 and s_stb=0; m0 drops cyc; m1 granted next S_IDLE.
4. QUOTA reached with m1 idle -> m0 keeps the grant; ack 40 beats uninterrupted, no rty.
5. TIMEOUT=8, slave never responds to m1 -> m1_err pulses at cycle 8 of stb; arb_tmo=1; m1 (cyc still high) not regranted until it drops cyc; m0 served meanwhile.
6. Assert wb_rst_i mid-burst during S_DRAIN -> s_cyc, all rty/ack/err and arb_gnt are 0 immediately; after release, an m0/m1 tie grants m0.
